inv_ark_stage: RTL and testbench
================================

// Module: inv_ark_stage
// PURPOSE
//  Inverse-cipher AddRoundKey stage with on-chip round-key store and per-block round sequencing.
//  Consumes InvSubBytes output (and, for a block's first beat, the raw ciphertext).
//  XORs each beat with the round key for that round and emits it, tagged with the round index:
//   - rounds NR-1..1 feed inv_mix_col;
//   - round NR (whitening) feeds InvShiftRows;
//   - round 0 is plaintext.
//  Byte order is big-endian [0:127], S(row,col) column-major, matching the InvMixColumns datapath.
// PARAMETERS
//  NR   10  cipher rounds (10/12/14); key store depth NR+1, addresses 0..NR
// PORTS
//  clk        in   1    rising-edge clock (one clock domain)
//  rst_n      in   1    reset, synchronous, active-low
//  key_we     in   1    round-key write strobe
//  key_waddr  in   4    round-key index 0..NR; index > NR ignored
//  key_wdata  in   128  round key [0:127]
//  in_valid   in   1    input beat valid
//  in_ready   out  1    stage can accept a beat
//  in_first   in   1    beat is the first (ciphertext) beat of a new block
//  in_state   in   128  state [0:127]
//  out_valid  out  1    output beat valid
//  out_ready  in   1    consumer accepts beat
//  out_state  out  128  state XOR round key
//  out_round  out  4    round index whose key was applied (NR..0)
//  out_mix    out  1    1 when 1 <= out_round <= NR-1 (route to inv_mix_col)
//  out_last   out  1    1 when out_round == 0 (plaintext)
//  err        out  1    one-cycle protocol/key error pulse
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - out_valid=0, out_state=0, out_round=0, out_mix=0, out_last=0, err=0, in_ready=0;
//   - FSM=IDLE, key_loaded mask=0, skid buffer emptied.
//   - in_ready rises the first cycle after release. Key data registers are NOT reset.
//  Key store:
//   - key_we writes key[key_waddr] and sets key_loaded[key_waddr].
//   - Same-cycle write and read of one index: the beat uses the OLD key (read-before-write).
//  Accept: in_valid & in_ready at posedge. Nothing else changes state on the data side.
//  FSM (round counter cnt, 4 bits):
//   - IDLE, accepted in_first=1: apply key[NR], tag NR, cnt:=NR-1, go ACTIVE.
//   - IDLE, accepted in_first=0: beat discarded (no output), err=1.
//   - ACTIVE, in_first=0: apply key[cnt], tag cnt. cnt==0 -> IDLE, else cnt:=cnt-1.
//   - ACTIVE, in_first=1: current block aborted, err=1; beat treated as IDLE+first.
//   - Beat using a key with key_loaded=0: still processed and emitted, err=1.
//  Datapath: out_state = in_state ^ key[r], pure bitwise XOR, no carries.
//   - out_mix and out_last are decoded from r, registered with out_state.
//  Latency: 1 cycle accept -> out_valid when unstalled. Throughput 1 beat/clk sustained.
//  Back-pressure: 2-entry skid buffer.
//   - in_ready = registered !full; never combinationally depends on out_ready.
//   - out_* hold stable while out_valid & !out_ready.
//   - Simultaneous push and pop on full: pop frees the entry; in_ready stays low that cycle.
//   - Simultaneous push and pop on one entry: occupancy unchanged.
//  Order preserved; no beat dropped except the IDLE non-first case.
//  Reset mid-block: all in-flight beats lost, no output, FSM IDLE; keys must be reloaded (mask=0).
// STRUCTURE
//  Shared package aes_pkg:
//   - localparams AES_DW=128, AES_NR128=10, AES_NR192=12, AES_NR256=14;
//   - typedef aes_state_t [0:127];
//   - round-tag width 4.
//  One sub-module: aes_skid_buf (2-entry valid/ready buffer, payload width param).
//   - Payload = {out_state, out_round, out_mix, out_last}.
//  Key store, FSM, and XOR stay in this module.
// TESTING
//  1. FIPS-197 C.1 keys loaded; first beat 69c4e0d86a7b0430d8cdb78070b4c55a:
//     -> out_state 7ad5fda789ef4e272bca100b3d9ff59f, out_round=10, mix=0, last=0.
//  2. Full C.1 decrypt loop (reference InvShiftRows/InvSubBytes/inv_mix_col model):
//     -> 11 beats tagged 10..0, mix=1 for 9..1, last beat 00112233445566778899aabbccddeeff.
//  3. out_ready held low 5 cycles mid-block with in_valid=1:
//     -> in_ready low after 2 accepts, out_state stable, no loss/reorder after release.
//  4. Non-first beat in IDLE -> err pulse, no out_valid.
//     in_first at cnt=4 -> err, out_round=10 next.
//  5. key[3] never written, block run -> err exactly on round-3 beat.
//     key_we addr 15 -> no effect.
//  6. rst_n low 1 cycle at round 6 with 2 beats buffered:
//     -> out_valid=0 next cycle, in_ready=1 the cycle after, FSM IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath width, round counts, the big-endian state
// type [0:127] (byte 0 = bits 0..7, column-major S(row,col)), the round-tag
// type and the AddRoundKey stage FSM encoding.
package aes_pkg;

  localparam int unsigned AES_DW    = 128;
  localparam int unsigned AES_NR128 = 10;
  localparam int unsigned AES_NR192 = 12;
  localparam int unsigned AES_NR256 = 14;
  localparam int unsigned AES_RW    = 4;

  typedef logic [0:AES_DW-1] aes_state_t;
  typedef logic [AES_RW-1:0] aes_round_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ark_fsm_e;

endpackage

// File: rtl/inv_ark_stage_if.sv
// Beat bus of the inverse AddRoundKey stage.
//   in_*  : upstream beat (valid/ready/first/state) into the stage
//   out_* : tagged result beat (valid/ready/state/round/mix/last) out of it
// slave  = the stage's view, master = the surrounding pipeline's view.
interface inv_ark_stage_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       in_first;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;
  aes_round_t out_round;
  logic       out_mix;
  logic       out_last;

  modport slave (
    input  in_valid, in_first, in_state, out_ready,
    output in_ready, out_valid, out_state, out_round, out_mix, out_last
  );

  modport master (
    output in_valid, in_first, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_mix, out_last
  );

endinterface

// File: rtl/aes_skid_buf.sv
// Two-entry valid/ready buffer.
//   clk, rst_n   : clock, synchronous active-low reset (empties buffer)
//   push         : write push_data this cycle (only honoured while in_ready)
//   in_ready     : registered "not full"; independent of out_ready
//   out_valid    : head entry valid
//   out_ready    : consumer takes head entry
//   pop_data     : head entry, held stable while stalled
module aes_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] ent0_q;  // head
  logic [W-1:0] ent1_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         rdy_q;
  logic         do_push;
  logic         do_pop;

  assign do_push   = push & rdy_q;
  assign do_pop    = (cnt_q != 2'd0) & out_ready;
  assign cnt_d     = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop_data  = ent0_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // A pop on a full buffer only frees the slot for the next cycle.
      rdy_q <= (cnt_d != 2'd2);
      if (do_pop) begin
        if (do_push && cnt_q == 2'd1) begin
          ent0_q <= push_data;
        end else begin
          ent0_q <= ent1_q;
          if (do_push) ent1_q <= push_data;
        end
      end else if (do_push) begin
        if (cnt_q == 2'd0) ent0_q <= push_data;
        else               ent1_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/inv_ark_stage.sv
// Inverse-cipher AddRoundKey stage with round-key store and per-block round
// sequencing. Each accepted beat is XORed with key[r] and emitted tagged r:
// first beat of a block uses r=NR, following beats NR-1 down to 0.
//   clk, rst_n          : clock, synchronous active-low reset
//   key_we/waddr/wdata  : round-key write (index > NR ignored)
//   bus (slave)         : in_* beat in, out_* tagged beat out
//   err                 : one-cycle pulse on protocol or unloaded-key error
module inv_ark_stage
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_we,
  input  logic [3:0]     key_waddr,
  input  aes_state_t     key_wdata,
  inv_ark_stage_if.slave bus,
  output logic           err
);

  localparam int unsigned PW     = AES_DW + AES_RW + 2;
  localparam aes_round_t  NR_TAG = aes_round_t'(NR);

  aes_state_t    key_mem [NR+1];
  logic [NR:0]   key_loaded;
  ark_fsm_e      state_q, state_d;
  aes_round_t    cnt_q, cnt_d;
  aes_round_t    rnd;
  logic          accept;
  logic          emit;
  logic          err_d;
  logic          mix;
  logic          last;
  logic          in_ready;
  aes_state_t    xor_state;
  logic [PW-1:0] push_data;
  logic [PW-1:0] pop_data;

  // Key data carries no reset; only the loaded mask is cleared.
  always_ff @(posedge clk) begin
    if (key_we && key_waddr <= NR_TAG) key_mem[key_waddr] <= key_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_loaded <= '0;
    end else if (key_we && key_waddr <= NR_TAG) begin
      key_loaded[key_waddr] <= 1'b1;
    end
  end

  assign accept = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd     = NR_TAG;
    emit    = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (bus.in_first) begin
        // A first beat always restarts; inside a block it aborts the old one.
        emit    = 1'b1;
        cnt_d   = NR_TAG - 4'd1;
        state_d = ST_ACTIVE;
        err_d   = (state_q == ST_ACTIVE);
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        rnd  = cnt_q;
        emit = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      if (emit && !key_loaded[rnd]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
    end
  end

  // Read happens before this edge's key write lands: same-index write uses old key.
  assign xor_state = bus.in_state ^ key_mem[rnd];
  assign mix       = (rnd != '0) && (rnd < NR_TAG);
  assign last      = (rnd == '0);
  assign push_data = {xor_state, rnd, mix, last};

  aes_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (emit),
    .push_data (push_data),
    .in_ready  (in_ready),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .pop_data  (pop_data)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_state = pop_data[PW-1 -: AES_DW];
  assign bus.out_round = pop_data[AES_RW+1 -: AES_RW];
  assign bus.out_mix   = pop_data[1];
  assign bus.out_last  = pop_data[0];

endmodule

// File: tb/tb_inv_ark_stage.sv
module tb_inv_ark_stage;
  import aes_pkg::*;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ALT = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_we = 1'b0;
  logic [3:0]   key_waddr = 4'd0;
  logic [127:0] key_wdata = '0;
  logic         err;
  logic [7:0]   ctrl;
  int           total = 0;
  int           bad = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk [11];
  logic [127:0] mdl_in [11];
  logic [127:0] mdl_out [11];

  inv_ark_stage_if ifc();

  inv_ark_stage #(.NR(AES_NR128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_waddr (key_waddr),
    .key_wdata (key_wdata),
    .bus       (ifc),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign ctrl = {ifc.out_valid, ifc.out_round, ifc.out_mix, ifc.out_last, err};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = isbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
      o[119-32*c -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
      o[111-32*c -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
      o[103-32*c -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] exp_ctrl(input int r, input logic e);
    return {1'b1, 4'(r), (r >= 1 && r <= 9), (r == 0), e};
  endfunction

  task automatic build_model;
    logic [7:0]  p, b, s, rc;
    logic [31:0] t;
    logic [31:0] w [44];
    for (int i = 0; i < 256; i++) begin
      p = 8'h01;
      for (int j = 0; j < 254; j++) p = gm(p, 8'(i));
      b = p;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox[i]  = s;
      isbox[s] = 8'(i);
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    mdl_in[10] = CT;
    for (int r = 10; r >= 0; r--) begin
      mdl_out[r] = mdl_in[r] ^ rk[r];
      if (r == 10)    mdl_in[r-1] = inv_sub(inv_shift(mdl_out[r]));
      else if (r > 0) mdl_in[r-1] = inv_sub(inv_shift(inv_mix(mdl_out[r])));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic first);
    ifc.in_valid = 1'b1;
    ifc.in_first = first;
    ifc.in_state = mdl_in[r];
  endtask

  task automatic settle;
    ifc.in_valid  = 1'b0;
    ifc.in_first  = 1'b0;
    ifc.out_ready = 1'b1;
    tick;
  endtask

  task automatic load_keys(input int skip);
    for (int i = 0; i <= 10; i++) begin
      if (i != skip) begin
        key_we    = 1'b1;
        key_waddr = 4'(i);
        key_wdata = rk[i];
        tick;
      end
    end
    key_we = 1'b0;
  endtask

  task automatic restart(input int skip);
    ifc.in_valid = 1'b0;
    ifc.in_first = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    load_keys(skip);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_first = 1'b1;
    ifc.in_state = CT;
    ifc.out_ready = 1'b1;
    tick;
    tick;
    total++;
    if ({ctrl, ifc.in_ready} !== 9'h000) begin
      bad++;
      $display("FAIL reset_ctrl: got {v,round,mix,last,err,rdy}=%b want 000000000", {ctrl, ifc.in_ready});
    end
    total++;
    if (ifc.out_state !== 128'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", ifc.out_state);
    end
    ifc.in_valid = 1'b0;
    ifc.in_first = 1'b0;
    rst_n = 1'b1;
    tick;
    total++;
    if ({ifc.in_ready, ifc.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release: got {rdy,v}=%b want 10", {ifc.in_ready, ifc.out_valid});
    end
  endtask

  task automatic test_first_beat;
    ifc.out_ready = 1'b1;
    drive(10, 1'b1);
    tick;
    ifc.in_valid = 1'b0;
    total++;
    if (ifc.out_state !== 128'h7ad5fda789ef4e272bca100b3d9ff59f) begin
      bad++;
      $display("FAIL first_state: got %h want 7ad5fda789ef4e272bca100b3d9ff59f", ifc.out_state);
    end
    total++;
    if (ctrl !== exp_ctrl(10, 1'b0)) begin
      bad++;
      $display("FAIL first_ctrl: got %b want %b", ctrl, exp_ctrl(10, 1'b0));
    end
  endtask

  task automatic test_decrypt_loop;
    ifc.out_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      drive(r, r == 10);
      total++;
      if (ifc.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL loop_ready r=%0d: got %b want 1", r, ifc.in_ready);
      end
      tick;
      total++;
      if (ctrl !== exp_ctrl(r, 1'b0)) begin
        bad++;
        $display("FAIL loop_ctrl r=%0d: got %b want %b", r, ctrl, exp_ctrl(r, 1'b0));
      end
      total++;
      if (ifc.out_state !== mdl_out[r]) begin
        bad++;
        $display("FAIL loop_state r=%0d: got %h want %h", r, ifc.out_state, mdl_out[r]);
      end
    end
    ifc.in_valid = 1'b0;
    total++;
    if (ifc.out_state !== PT) begin
      bad++;
      $display("FAIL loop_plaintext: got %h want %h", ifc.out_state, PT);
    end
  endtask

  task automatic test_back_to_back;
    int   nin, nout, cyc;
    logic acc, pop;
    settle;
    nin = 10;
    nout = 10;
    cyc = 0;
    while (nout >= 0 && cyc < 60) begin
      ifc.out_ready = (cyc >= 5);
      if (nin >= 0) drive(nin, nin == 10);
      else ifc.in_valid = 1'b0;
      if (cyc >= 2 && cyc <= 4) begin
        total++;
        if (ifc.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready_low cyc=%0d: got %b want 0", cyc, ifc.in_ready);
        end
      end
      if (ifc.out_valid === 1'b1) begin
        total++;
        if (ifc.out_state !== mdl_out[nout] || ifc.out_round !== 4'(nout) || err !== 1'b0) begin
          bad++;
          $display("FAIL bp_head cyc=%0d: got round=%0d err=%b state=%h want round=%0d err=0 state=%h",
                   cyc, ifc.out_round, err, ifc.out_state, nout, mdl_out[nout]);
        end
      end
      acc = ifc.in_valid & ifc.in_ready;
      pop = ifc.out_valid & ifc.out_ready;
      tick;
      if (acc) nin--;
      if (pop) nout--;
      cyc++;
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    total++;
    if (nout != -1) begin
      bad++;
      $display("FAIL bp_drain: got next expected round %0d after %0d cycles want all 11 beats", nout, cyc);
    end
  endtask

  task automatic test_protocol_err;
    settle;
    drive(5, 1'b0);
    tick;
    ifc.in_valid = 1'b0;
    total++;
    if ({ifc.out_valid, err} !== 2'b01) begin
      bad++;
      $display("FAIL idle_nonfirst: got {v,err}=%b want 01", {ifc.out_valid, err});
    end
    tick;
    total++;
    if ({ifc.out_valid, err} !== 2'b00) begin
      bad++;
      $display("FAIL err_pulse: got {v,err}=%b want 00", {ifc.out_valid, err});
    end
    for (int r = 10; r >= 5; r--) begin
      drive(r, r == 10);
      tick;
      total++;
      if (ctrl !== exp_ctrl(r, 1'b0)) begin
        bad++;
        $display("FAIL pre_abort r=%0d: got %b want %b", r, ctrl, exp_ctrl(r, 1'b0));
      end
    end
    drive(10, 1'b1);
    tick;
    total++;
    if (ctrl !== exp_ctrl(10, 1'b1)) begin
      bad++;
      $display("FAIL abort_ctrl: got %b want %b", ctrl, exp_ctrl(10, 1'b1));
    end
    total++;
    if (ifc.out_state !== mdl_out[10]) begin
      bad++;
      $display("FAIL abort_state: got %h want %h", ifc.out_state, mdl_out[10]);
    end
    for (int r = 9; r >= 0; r--) begin
      drive(r, 1'b0);
      tick;
      total++;
      if (ctrl !== exp_ctrl(r, 1'b0)) begin
        bad++;
        $display("FAIL post_abort r=%0d: got %b want %b", r, ctrl, exp_ctrl(r, 1'b0));
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_key_rbw;
    settle;
    drive(10, 1'b1);
    key_we    = 1'b1;
    key_waddr = 4'd10;
    key_wdata = ALT;
    tick;
    key_we = 1'b0;
    total++;
    if (ifc.out_state !== (CT ^ rk[10]) || ctrl !== exp_ctrl(10, 1'b0)) begin
      bad++;
      $display("FAIL rbw_old: got state=%h ctrl=%b want state=%h ctrl=%b",
               ifc.out_state, ctrl, CT ^ rk[10], exp_ctrl(10, 1'b0));
    end
    drive(10, 1'b1);
    tick;
    ifc.in_valid = 1'b0;
    total++;
    if (ifc.out_state !== (CT ^ ALT) || ctrl !== exp_ctrl(10, 1'b1)) begin
      bad++;
      $display("FAIL rbw_new: got state=%h ctrl=%b want state=%h ctrl=%b",
               ifc.out_state, ctrl, CT ^ ALT, exp_ctrl(10, 1'b1));
    end
  endtask

  task automatic test_key_unloaded;
    restart(3);
    key_we    = 1'b1;
    key_wdata = ALT;
    key_waddr = 4'd15;
    tick;
    key_waddr = 4'd11;
    tick;
    key_we = 1'b0;
    ifc.out_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      drive(r, r == 10);
      tick;
      total++;
      if (ctrl !== exp_ctrl(r, r == 3)) begin
        bad++;
        $display("FAIL unloaded_ctrl r=%0d: got %b want %b", r, ctrl, exp_ctrl(r, r == 3));
      end
      total++;
      if (ifc.out_state !== mdl_out[r]) begin
        bad++;
        $display("FAIL unloaded_state r=%0d: got %h want %h", r, ifc.out_state, mdl_out[r]);
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_block;
    restart(-1);
    ifc.out_ready = 1'b1;
    for (int r = 10; r >= 7; r--) begin
      drive(r, r == 10);
      tick;
    end
    ifc.out_ready = 1'b0;
    drive(6, 1'b0);
    tick;
    total++;
    if ({ifc.out_valid, ifc.in_ready, ifc.out_round} !== {1'b1, 1'b0, 4'd7}) begin
      bad++;
      $display("FAIL pre_reset: got v=%b rdy=%b round=%0d want v=1 rdy=0 round=7",
               ifc.out_valid, ifc.in_ready, ifc.out_round);
    end
    rst_n = 1'b0;
    drive(5, 1'b0);
    ifc.out_ready = 1'b1;
    tick;
    total++;
    if ({ctrl, ifc.in_ready} !== 9'h000) begin
      bad++;
      $display("FAIL mid_reset: got {v,round,mix,last,err,rdy}=%b want 000000000", {ctrl, ifc.in_ready});
    end
    rst_n = 1'b1;
    ifc.in_valid = 1'b0;
    tick;
    total++;
    if ({ifc.in_ready, ifc.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL mid_release: got {rdy,v}=%b want 10", {ifc.in_ready, ifc.out_valid});
    end
    drive(5, 1'b0);
    tick;
    total++;
    if ({ifc.out_valid, err} !== 2'b01) begin
      bad++;
      $display("FAIL mid_idle: got {v,err}=%b want 01", {ifc.out_valid, err});
    end
    drive(10, 1'b1);
    tick;
    ifc.in_valid = 1'b0;
    total++;
    if (ctrl !== exp_ctrl(10, 1'b1) || ifc.out_state !== mdl_out[10]) begin
      bad++;
      $display("FAIL mid_mask: got ctrl=%b state=%h want ctrl=%b state=%h",
               ctrl, ifc.out_state, exp_ctrl(10, 1'b1), mdl_out[10]);
    end
    tick;
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_first  = 1'b0;
    ifc.in_state  = '0;
    ifc.out_ready = 1'b1;
    build_model;
    test_reset;
    load_keys(-1);
    test_first_beat;
    restart(-1);
    test_decrypt_loop;
    test_back_to_back;
    test_protocol_err;
    test_key_rbw;
    restart(-1);
    test_key_unloaded;
    test_reset_mid_block;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
